// File: rtl/reg_dump_pkg.sv
// Shared types and defaults for the debug register-readout scanner.
package reg_dump_pkg;

    localparam int SW_DEF = 5;
    localparam int DW_DEF = 32;
    localparam int NREG   = 1 << SW_DEF;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        VALID,
        DONE
    } state_t;

endpackage

// File: rtl/reg_dump_scanner.sv
// Walks a wrapping range of register indices on the CPU debug port and
// streams each captured (index, value) pair out over valid/ready.
module reg_dump_scanner
    import reg_dump_pkg::*;
#(
    parameter int SW       = SW_DEF,
    parameter int DW       = DW_DEF,
    parameter int READ_LAT = 0
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic          abort,
    input  logic [SW-1:0] first_sel,
    input  logic [SW-1:0] last_sel,
    output logic [SW-1:0] reg_sel,
    input  logic [DW-1:0] reg_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [SW-1:0] out_sel,
    output logic [DW-1:0] out_data,
    output logic          busy,
    output logic          done
);

    localparam int            CW  = (READ_LAT < 1) ? 1 : $clog2(READ_LAT + 1);
    localparam logic [CW-1:0] LAT = CW'(READ_LAT);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [SW-1:0] last_q, last_n;
    logic [SW-1:0] sel_n, osel_n;
    logic [DW-1:0] odata_n;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            cnt      <= '0;
            last_q   <= '0;
            reg_sel  <= '0;
            out_sel  <= '0;
            out_data <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            last_q   <= last_n;
            reg_sel  <= sel_n;
            out_sel  <= osel_n;
            out_data <= odata_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        last_n  = last_q;
        sel_n   = reg_sel;
        osel_n  = out_sel;
        odata_n = out_data;
        // Abort beats everything, including an entry transferring on the same edge.
        if (abort && state != IDLE) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        last_n  = last_sel;
                        sel_n   = first_sel;
                        cnt_n   = '0;
                        state_n = SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == LAT) begin
                        odata_n = reg_data;
                        osel_n  = reg_sel;
                        state_n = VALID;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                VALID: begin
                    if (out_ready) begin
                        if (out_sel == last_q) begin
                            state_n = DONE;
                        end else begin
                            sel_n   = reg_sel + 1'b1;  // wraps naturally at 2^SW
                            cnt_n   = '0;
                            state_n = SETUP;
                        end
                    end
                end
                DONE:    state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    assign out_valid = (state == VALID);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

endmodule

// File: doc/reg_dump_scanner.md
Name: reg_dump_scanner

Overview:
- Hardware initiator for the CPU's debug register-readout port (reg_sel out, reg_data in).
- On a start pulse it walks a programmable range of register indices and drives each one onto reg_sel.
- It samples reg_data after a fixed read latency and streams each (index, value) pair out over a valid/ready handshake.
- Sits between the single-cycle CPU top and a downstream consumer (display/serial/bench monitor), replacing manual reg_sel poking.

Parameters:
- SW, 5, register index width (32 architectural registers)
- DW, 32, register data width
- READ_LAT, 0, cycles reg_sel must be held before reg_data is sampled (0 = combinational regfile read)

Ports:
- clk  in  1  system clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- start  in  1  begin a scan; sampled only in IDLE
- abort  in  1  synchronous cancel of a scan in progress
- first_sel  in  SW  first index of range; latched at start
- last_sel  in  SW  last index of range; latched at start
- reg_sel  out  SW  register index driven to the CPU debug port (registered)
- reg_data  in  DW  register value returned by the CPU for reg_sel
- out_valid  out  1  out_sel/out_data hold a captured entry
- out_ready  in  1  consumer accepts the entry
- out_sel  out  SW  index of the captured entry
- out_data  out  DW  captured value
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse after the last entry transfers

Behaviour:
- Reset (async, rstn=0): state IDLE; reg_sel, out_sel, out_data, wait counter = 0; out_valid, busy, done = 0. Takes effect immediately, including mid-scan. No done pulse is generated.
- FSM states: IDLE, SETUP, VALID, DONE.
- IDLE, start=1 at an edge: latch first/last, reg_sel <= first_sel, wait counter <= 0, go to SETUP.
- start while busy is ignored.
- SETUP: reg_sel held. Counter increments each cycle. At the edge where counter == READ_LAT: out_data <= reg_data, out_sel <= reg_sel, go to VALID. SETUP therefore lasts READ_LAT+1 cycles.
- VALID: out_valid=1.
  - Transfer occurs at an edge with out_valid & out_ready.
  - out_sel/out_data must stay stable while out_valid & !out_ready.
  - After transfer, if out_sel == latched last: go to DONE.
  - Otherwise: reg_sel <= reg_sel+1 (mod 2^SW), counter <= 0, go to SETUP.
- DONE: done=1 for exactly one cycle, busy=1; next edge goes to IDLE.
- Range wrap: if first > last, the index wraps 31 -> 0. Entry count = ((last - first) mod 32) + 1. first == last gives exactly one entry. A full 32-entry scan is first=N, last=N-1.
- Throughput: one entry per READ_LAT+2 cycles with out_ready tied high. Stalls extend VALID only.
- out_valid is registered and never depends combinationally on out_ready.
- abort=1 at any edge with state != IDLE: go to IDLE, out_valid drops, no done pulse. This is the only case where valid may drop without a transfer.
  - abort has priority over a simultaneous transfer; an entry transferring on that edge is considered dropped.
  - abort in IDLE has no effect.
  - abort and start together in IDLE: start wins.
- reg_sel retains its last value in IDLE.

Decomposition:
- Package reg_dump_pkg holds:
  - state enum {IDLE, SETUP, VALID, DONE}
  - SW/DW default constants
  - NREG = 1<<SW
- Single module. The wait counter and the wrap-increment are simple enough to inline, so no sub-module is needed.

Test Plan:
- Stub regfile reg[i] = 32'hA500_0000 | i, READ_LAT=0, ready=1, first=0, last=31, start pulse at edge E0 -> 32 transfers with sel 0..31 and data A500_0000..A500_001F in order; transfer k at E(2k+2); done high in the cycle after E64; busy low after E65.
- first=30, last=1, ready=1 -> exactly 4 entries, sel 30, 31, 0, 1; done once.
- first=last=7, READ_LAT=2 -> reg_sel=7 held 3 cycles in SETUP; one entry (7, A500_0007); done after its transfer.
- Stub regfile with 2-cycle read delay; out_ready toggled 0,0,1 per entry -> each entry held stable for 2 stall cycles; no index skipped or repeated; data matches the delayed regfile.
- Scan 0..31; abort asserted while out_valid=1 on entry 5 -> IDLE next edge, out_valid=0, no done; a new start with 3..4 then yields entries 3 and 4 only.
- Scan 0..31; rstn pulled low mid-scan between edges -> out_valid, busy, done and reg_sel go to 0 immediately; after release the block stays IDLE until the next start.
